multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter ALU_CTRL_W, default 4: width of alu_ctrl; legal values are 4 or greater.
REQ-002 Parameter STATE_W, default 4: width of the state debug output; legal values are 4 or greater.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 op  in  6  opcode field of the instruction register.
REQ-006 func  in  6  function field of the instruction register.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory access completes in the cycle this is high.
REQ-009 mem_read, mem_write  out  1 each  memory access strobes.
REQ-010 i_or_d  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-011 ir_write, pc_en  out  1 each  instruction-register load and PC load enables.
REQ-012 reg_write, reg_dst, mem_to_reg  out  1 each  register-file write, destination select (1 = rd), writeback select (1 = memory data).
REQ-013 alu_src_a  out  1; alu_src_b  out  2; pc_src  out  2  ALU operand selects and next-PC select.
REQ-014 alu_ctrl  out  ALU_CTRL_W  ALU operation; 4-bit codes zero-extended to ALU_CTRL_W.
REQ-015 state  out  STATE_W; instr_done  out  1; illegal_op  out  1  current state, instruction-retire pulse, sticky fault flag.

Function
REQ-016 Moore FSM with these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, HALT=10.
REQ-017 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=0010, pc_src=00; ir_write and pc_en assert only in the cycle mem_ready=1, and FETCH advances to DECODE only in that cycle.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=0010; next state by op: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP (only with MC_JUMP_EN); any other op -> HALT.
REQ-019 DECODE with op=000000 and func not in {100100, 100101, 100000, 100010, 101010, 100111} -> HALT.
REQ-020 MEMADR: alu_src_a=1, alu_src_b=10, alu_ctrl=0010; op 100011 -> MEMRD, otherwise -> MEMWR.
REQ-021 MEMRD: mem_read=1, i_or_d=1; holds until mem_ready=1, then -> MEMWB.
REQ-022 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1; -> FETCH.
REQ-023 MEMWR: mem_write=1, i_or_d=1; holds until mem_ready=1; instr_done=1 in that cycle; then -> FETCH.
REQ-024 EXEC: alu_src_a=1, alu_src_b=00; alu_ctrl by func: and=0000, or=0001, add=0010, sub=0110, slt=0111, nor=1100; -> ALUWB.
REQ-025 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; -> FETCH.
REQ-026 BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=0110, pc_src=01, pc_en=zero, instr_done=1; -> FETCH.
REQ-027 JUMP: pc_src=10, pc_en=1, instr_done=1; -> FETCH.
REQ-028 HALT: absorbing state; all strobes 0; illegal_op set on entry and held until reset.
REQ-029 Outputs not listed for a state are 0; alu_ctrl defaults to 0010.
REQ-030 mem_read and mem_write are never high in the same cycle; at most one of pc_en and reg_write pulses per instruction-retire cycle.

Reset
REQ-031 reset low asynchronously forces state=FETCH and illegal_op=0; while reset is low, every strobe (mem_read, mem_write, ir_write, pc_en, reg_write, instr_done) is 0.
REQ-032 After reset is released, the first FETCH begins on the next rising edge; reset asserted mid-access abandons the access without any pc_en or reg_write pulse.

Configuration
REQ-033 With macro MC_JUMP_EN defined, op 000010 goes to JUMP; without it, the JUMP state is not built and op 000010 goes to HALT with illegal_op=1.

Verification
REQ-034 add (op=000000, func=100000) with mem_ready tied high -> state sequence 0,1,6,7,0; alu_ctrl=0010 in EXEC; reg_write=1 and reg_dst=1 in ALUWB; one instr_done pulse.
REQ-035 lw with mem_ready low for 3 cycles in FETCH and in MEMRD -> each state held 4 cycles; ir_write pulses exactly once; reg_write with mem_to_reg=1 in MEMWB.
REQ-036 beq with zero=1, then beq with zero=0 -> pc_en=1 in BRANCH for the first and 0 for the second; alu_ctrl=0110 in both.
REQ-037 op=111111, then R-type with func=000000 -> both reach state 10 with illegal_op=1; all strobes stay 0 until reset; reset returns state to 0.
REQ-038 reset low during MEMWR with mem_ready=0 -> state=0 immediately; mem_write=0 while reset is low; no instr_done pulse.
REQ-039 op=000010 -> with MC_JUMP_EN: state 9, pc_src=10, pc_en=1; without it: state 10, illegal_op=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM with memory-ready handshake and sticky illegal-op flag.
// Define MC_JUMP_EN to build the JUMP state; otherwise op 000010 traps to HALT.
module multicycle_ctrl #(
    parameter int ALU_CTRL_W = 4,
    parameter int STATE_W    = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [5:0]            i_op,
    input  logic [5:0]            i_func,
    input  logic                  i_zero,
    input  logic                  i_mem_ready,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_i_or_d,
    output logic                  o_ir_write,
    output logic                  o_pc_en,
    output logic                  o_reg_write,
    output logic                  o_reg_dst,
    output logic                  o_mem_to_reg,
    output logic                  o_alu_src_a,
    output logic [1:0]            o_alu_src_b,
    output logic [1:0]            o_pc_src,
    output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
    output logic [STATE_W-1:0]    o_state,
    output logic                  o_instr_done,
    output logic                  o_illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    state_t     r_state, w_next;
    logic       r_active;
    logic       r_illegal_op;
    logic       w_func_ok;
    logic       w_mem_read, w_mem_write, w_i_or_d, w_ir_write, w_pc_en;
    logic       w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src_a, w_instr_done;
    logic [1:0] w_alu_src_b, w_pc_src;
    logic [3:0] w_alu_ctrl;

    assign w_func_ok = i_func inside {6'b100100, 6'b100101, 6'b100000,
                                      6'b100010, 6'b101010, 6'b100111};

    // r_active holds the machine idle in FETCH until the first edge after reset release
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_FETCH;
            r_active     <= 1'b0;
            r_illegal_op <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_active <= 1'b1;
            if (w_next == S_HALT)
                r_illegal_op <= 1'b1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_i_or_d     = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_en      = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_pc_src     = 2'b00;
        w_alu_ctrl   = 4'b0010;
        w_instr_done = 1'b0;
        if (!r_active) begin
            w_next = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: begin
                    w_mem_read  = 1'b1;
                    w_alu_src_b = 2'b01;
                    w_ir_write  = i_mem_ready;
                    w_pc_en     = i_mem_ready;
                    if (i_mem_ready)
                        w_next = S_DECODE;
                end
                S_DECODE: begin
                    w_alu_src_b = 2'b11;
                    case (i_op)
                        OP_LW, OP_SW: w_next = S_MEMADR;
                        OP_RTYPE:     w_next = w_func_ok ? S_EXEC : S_HALT;
                        OP_BEQ:       w_next = S_BRANCH;
`ifdef MC_JUMP_EN
                        OP_J:         w_next = S_JUMP;
`endif
                        default:      w_next = S_HALT;
                    endcase
                end
                S_MEMADR: begin
                    w_alu_src_a = 1'b1;
                    w_alu_src_b = 2'b10;
                    w_next      = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    w_mem_read = 1'b1;
                    w_i_or_d   = 1'b1;
                    if (i_mem_ready)
                        w_next = S_MEMWB;
                end
                S_MEMWB: begin
                    w_reg_write  = 1'b1;
                    w_mem_to_reg = 1'b1;
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end
                S_MEMWR: begin
                    w_mem_write  = 1'b1;
                    w_i_or_d     = 1'b1;
                    w_instr_done = i_mem_ready;
                    if (i_mem_ready)
                        w_next = S_FETCH;
                end
                S_EXEC: begin
                    w_alu_src_a = 1'b1;
                    case (i_func)
                        6'b100100: w_alu_ctrl = 4'b0000;
                        6'b100101: w_alu_ctrl = 4'b0001;
                        6'b100010: w_alu_ctrl = 4'b0110;
                        6'b101010: w_alu_ctrl = 4'b0111;
                        6'b100111: w_alu_ctrl = 4'b1100;
                        default:   w_alu_ctrl = 4'b0010;
                    endcase
                    w_next = S_ALUWB;
                end
                S_ALUWB: begin
                    w_reg_write  = 1'b1;
                    w_reg_dst    = 1'b1;
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end
                S_BRANCH: begin
                    w_alu_src_a  = 1'b1;
                    w_alu_ctrl   = 4'b0110;
                    w_pc_src     = 2'b01;
                    w_pc_en      = i_zero;
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end
`ifdef MC_JUMP_EN
                S_JUMP: begin
                    w_pc_src     = 2'b10;
                    w_pc_en      = 1'b1;
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end
`endif
                S_HALT:  w_next = S_HALT;
                // unused encodings are treated as a fault
                default: w_next = S_HALT;
            endcase
        end
    end

    assign o_mem_read   = w_mem_read;
    assign o_mem_write  = w_mem_write;
    assign o_i_or_d     = w_i_or_d;
    assign o_ir_write   = w_ir_write;
    assign o_pc_en      = w_pc_en;
    assign o_reg_write  = w_reg_write;
    assign o_reg_dst    = w_reg_dst;
    assign o_mem_to_reg = w_mem_to_reg;
    assign o_alu_src_a  = w_alu_src_a;
    assign o_alu_src_b  = w_alu_src_b;
    assign o_pc_src     = w_pc_src;
    assign o_alu_ctrl   = ALU_CTRL_W'(w_alu_ctrl);
    assign o_state      = STATE_W'(r_state);
    assign o_instr_done = w_instr_done;
    assign o_illegal_op = r_illegal_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model expands each
// instruction into an expected per-cycle trace which is replayed against the DUT.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = '0, func = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;

    logic       mem_read, mem_write, i_or_d, ir_write, pc_en, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] alu_ctrl, state;

    int checks = 0;
    int failures = 0;

`ifdef MC_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    multicycle_ctrl dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_op(op), .i_func(func), .i_zero(zero),
        .i_mem_ready(mem_ready), .o_mem_read(mem_read), .o_mem_write(mem_write),
        .o_i_or_d(i_or_d), .o_ir_write(ir_write), .o_pc_en(pc_en), .o_reg_write(reg_write),
        .o_reg_dst(reg_dst), .o_mem_to_reg(mem_to_reg), .o_alu_src_a(alu_src_a),
        .o_alu_src_b(alu_src_b), .o_pc_src(pc_src), .o_alu_ctrl(alu_ctrl), .o_state(state),
        .o_instr_done(instr_done), .o_illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // sel = {i_or_d, alu_src_a, alu_src_b, reg_dst, mem_to_reg}
    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic [5:0] strb;  // {ir_write, pc_en, reg_write, instr_done, mem_read, mem_write}
        logic       ill;
        logic [1:0] pcs;
        logic [3:0] alu;
        logic [5:0] sel;
    } cyc_t;

    cyc_t exp_q[$];

    function automatic cyc_t mk(input logic [3:0] st, input logic [5:0] sel);
        cyc_t c;
        c.st = st; c.mr = 1'($urandom_range(0, 1)); c.strb = '0; c.ill = 1'b0;
        c.pcs = 2'b00; c.alu = 4'b0010; c.sel = sel;
        return c;
    endfunction

    function automatic bit func_legal(input logic [5:0] f);
        return f == 6'b100100 || f == 6'b100101 || f == 6'b100000 ||
               f == 6'b100010 || f == 6'b101010 || f == 6'b100111;
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100010: return 4'b0110;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1100;
            default:   return 4'b0010;
        endcase
    endfunction

    // Expand one instruction into its expected cycle trace; fw/mw = ready wait cycles
    task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z,
                         input int fw, input int mw, output bit halts);
        cyc_t c;
        exp_q.delete();
        op = o; func = f; zero = z; halts = 1'b0;
        for (int i = 0; i <= fw; i++) begin
            c = mk(4'd0, 6'b000100); c.mr = (i == fw);
            c.strb = (i == fw) ? 6'b110010 : 6'b000010;
            exp_q.push_back(c);
        end
        exp_q.push_back(mk(4'd1, 6'b001100));
        if (o == 6'b100011 || o == 6'b101011) begin
            exp_q.push_back(mk(4'd2, 6'b011000));
            for (int i = 0; i <= mw; i++) begin
                if (o == 6'b100011) begin
                    c = mk(4'd3, 6'b100000); c.strb = 6'b000010;
                end else begin
                    c = mk(4'd5, 6'b100000);
                    c.strb = (i == mw) ? 6'b000101 : 6'b000001;
                end
                c.mr = (i == mw);
                exp_q.push_back(c);
            end
            if (o == 6'b100011) begin
                c = mk(4'd4, 6'b000001); c.strb = 6'b001100; exp_q.push_back(c);
            end
        end else if (o == 6'b000000 && func_legal(f)) begin
            c = mk(4'd6, 6'b010000); c.alu = alu_of(f); exp_q.push_back(c);
            c = mk(4'd7, 6'b000010); c.strb = 6'b001100; exp_q.push_back(c);
        end else if (o == 6'b000100) begin
            c = mk(4'd8, 6'b010000); c.alu = 4'b0110; c.pcs = 2'b01;
            c.strb = {1'b0, z, 4'b0100}; exp_q.push_back(c);
        end else if (o == 6'b000010 && JUMP_EN) begin
            c = mk(4'd9, 6'b000000); c.pcs = 2'b10; c.strb = 6'b010100; exp_q.push_back(c);
        end else begin
            halts = 1'b1;
            for (int i = 0; i < 4; i++) begin
                c = mk(4'd10, 6'b000000); c.ill = 1'b1; exp_q.push_back(c);
            end
        end
    endtask

    task automatic play(input int n, input string tag);
        cyc_t c;
        for (int k = 0; k < n; k++) begin
            c = exp_q.pop_front();
            mem_ready = c.mr;
            #1;
            checks++;
            if (state !== c.st) begin
                failures++;
                $display("FAIL %s.state cyc%0d got=%0d exp=%0d", tag, k, state, c.st);
            end
            checks++;
            if ({ir_write, pc_en, reg_write, instr_done, mem_read, mem_write} !== c.strb) begin
                failures++;
                $display("FAIL %s.strobes cyc%0d st=%0d got=%b exp=%b", tag, k, c.st,
                         {ir_write, pc_en, reg_write, instr_done, mem_read, mem_write}, c.strb);
            end
            checks++;
            if (illegal_op !== c.ill) begin
                failures++;
                $display("FAIL %s.illegal_op cyc%0d got=%b exp=%b", tag, k, illegal_op, c.ill);
            end
            checks++;
            if ({pc_src, alu_ctrl, i_or_d, alu_src_a, alu_src_b, reg_dst, mem_to_reg} !==
                {c.pcs, c.alu, c.sel}) begin
                failures++;
                $display("FAIL %s.datapath cyc%0d st=%0d got=%b exp=%b", tag, k, c.st,
                         {pc_src, alu_ctrl, i_or_d, alu_src_a, alu_src_b, reg_dst, mem_to_reg},
                         {c.pcs, c.alu, c.sel});
            end
            @(negedge clk);
        end
    endtask

    // Leaves the bench at a negedge with the first FETCH cycle about to be driven
    task automatic apply_reset(input string tag);
        rst_n = 1'b0; mem_ready = 1'b1;
        #2;
        checks++;
        if (state !== 4'd0 || illegal_op !== 1'b0 ||
            {ir_write, pc_en, reg_write, instr_done, mem_read, mem_write} !== 6'b0) begin
            failures++;
            $display("FAIL %s.in_reset got st=%0d ill=%b strb=%b exp st=0 ill=0 strb=0", tag,
                     state, illegal_op, {ir_write, pc_en, reg_write, instr_done, mem_read, mem_write});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || {ir_write, pc_en, reg_write, mem_read} !== 4'b0) begin
            failures++;
            $display("FAIL %s.release got st=%0d strb=%b exp st=0 strb=0", tag, state,
                     {ir_write, pc_en, reg_write, mem_read});
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_add();
        bit h;
        build(6'b000000, 6'b100000, 1'b0, 0, 0, h);
        foreach (exp_q[i]) exp_q[i].mr = 1'b1;
        play(exp_q.size(), "add");
    endtask

    task automatic test_lw_wait();
        bit h;
        build(6'b100011, 6'b000000, 1'b0, 3, 3, h);
        play(exp_q.size(), "lw_wait");
    endtask

    task automatic test_beq();
        bit h;
        build(6'b000100, 6'b000000, 1'b1, 1, 0, h);
        play(exp_q.size(), "beq_taken");
        build(6'b000100, 6'b000000, 1'b0, 0, 0, h);
        play(exp_q.size(), "beq_not_taken");
    endtask

    task automatic test_illegal();
        bit h;
        build(6'b111111, 6'b100000, 1'b0, 0, 0, h);
        play(exp_q.size(), "ill_op");
        apply_reset("ill_op_reset");
        build(6'b000000, 6'b000000, 1'b0, 2, 0, h);
        play(exp_q.size(), "ill_func");
        apply_reset("ill_func_reset");
    endtask

    task automatic test_jump();
        bit h;
        build(6'b000010, 6'b000000, 1'b0, 0, 0, h);
        play(exp_q.size(), "jump");
        if (h) apply_reset("jump_reset");
    endtask

    task automatic test_reset_mid_memwr();
        bit h;
        build(6'b101011, 6'b000000, 1'b0, 0, 5, h);
        play(exp_q.size() - 3, "sw_abort");
        exp_q.delete();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin
            failures++;
            $display("FAIL sw_abort.pre got st=%0d mem_write=%b exp st=5 mem_write=1", state, mem_write);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || {mem_write, instr_done, pc_en, reg_write} !== 4'b0) begin
            failures++;
            $display("FAIL sw_abort.async got st=%0d strb=%b exp st=0 strb=0", state,
                     {mem_write, instr_done, pc_en, reg_write});
        end
        @(posedge clk);
        #1;
        checks++;
        if (state !== 4'd0 || {mem_write, instr_done, pc_en, reg_write} !== 4'b0) begin
            failures++;
            $display("FAIL sw_abort.held got st=%0d strb=%b exp st=0 strb=0", state,
                     {mem_write, instr_done, pc_en, reg_write});
        end
        @(negedge clk);
        apply_reset("sw_abort_reset");
    endtask

    task automatic test_random();
        bit h;
        logic [5:0] o, f;
        for (int n = 0; n < 40; n++) begin
            f = 6'($urandom);
            case ($urandom_range(0, 6))
                0: o = 6'b100011;
                1: o = 6'b101011;
                2: begin
                    o = 6'b000000;
                    case ($urandom_range(0, 5))
                        0: f = 6'b100100; 1: f = 6'b100101; 2: f = 6'b100000;
                        3: f = 6'b100010; 4: f = 6'b101010; default: f = 6'b100111;
                    endcase
                end
                3: o = 6'b000100;
                4: o = 6'b000010;
                5: o = 6'b000000;
                default: begin
                    o = 6'($urandom);
                    while (o inside {6'b000000, 6'b000010, 6'b000100, 6'b100011, 6'b101011})
                        o = 6'($urandom);
                end
            endcase
            build(o, f, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), h);
            play(exp_q.size(), "random");
            if (h) apply_reset("random_reset");
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_jump();
        test_reset_mid_memwr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
